// File: rtl/mem_ctrl_rr.sv
// Byte-serial RAM controller: round-robin arbitration of NUM_PORTS requesters onto an 8-bit RAM.
// Latency: read pulse n+1 cycles after grant (n = 1/2/4 bytes), write pulse n cycles after grant, then one idle cycle.
// Backpressure: requests hold req_valid until resp_valid; rdy low blocks new grants only. Optional IO_BUFFER_FULL_STALL_EN stalls IO writes.
module mem_ctrl_rr #(
    parameter int          NUM_PORTS = 2,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] IO_BASE   = 32'h30000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        io_buffer_full,
    output logic [7:0]                  mem_din,
    input  logic [7:0]                  mem_dout,
    output logic [ADDR_W-1:0]           mem_a,
    output logic                        mem_wr,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [2*NUM_PORTS-1:0]      req_size,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
    input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        resp_valid,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic                        busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_ptr;       // last grantee; also the port of the current transaction
    logic                  r_wr;
    logic [2:0]            r_n;         // access length in bytes
    logic [2:0]            r_cnt;       // read: edges since grant; write: next byte to issue
    logic [ADDR_W-1:0]     r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic [7:0]            r_mem_din;
    logic [ADDR_W-1:0]     r_mem_a;
    logic                  r_mem_wr;
    logic [NUM_PORTS-1:0]  r_resp_valid;
    logic [DATA_W-1:0]     r_resp_rdata;
    logic                  r_busy;

    logic                  w_gnt_found;
    logic [PW-1:0]         w_gnt_idx;
    logic                  w_req_wr;
    logic [1:0]            w_req_size;
    logic [ADDR_W-1:0]     w_req_addr;
    logic [31:0]           w_req_wdata;
    logic [2:0]            w_req_n;
    int                    w_best;
    int                    w_dist;
    logic [31:0]           w_rd_next;
    logic [7:0]            w_wr_byte;
    logic [NUM_PORTS-1:0]  w_onehot;
    logic                  w_stall_grant;
    logic                  w_stall_wr;

    assign mem_din    = r_mem_din;
    assign mem_a      = r_mem_a;
    assign mem_wr     = r_mem_wr;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign busy       = r_busy;
    assign w_onehot   = NUM_PORTS'(1) << r_ptr;

`ifdef IO_BUFFER_FULL_STALL_EN
    // IO-region writes pause before each byte while the UART buffer is full
    assign w_stall_grant = io_buffer_full && (w_req_addr >= ADDR_W'(IO_BASE));
    assign w_stall_wr    = io_buffer_full && (r_addr >= ADDR_W'(IO_BASE));
`else
    logic w_unused_io;
    assign w_unused_io   = io_buffer_full;
    assign w_stall_grant = 1'b0;
    assign w_stall_wr    = 1'b0;
`endif

    // Round-robin pick: the valid port closest after r_ptr wins; its fields are muxed out alongside
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_req_wr    = 1'b0;
        w_req_size  = 2'd0;
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_best      = NUM_PORTS;
        w_dist      = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_dist = (p + 2 * NUM_PORTS - int'(r_ptr) - 1) % NUM_PORTS;
            if (req_valid[p] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_gnt_found = 1'b1;
                w_gnt_idx   = PW'(p);
                w_req_wr    = req_wr[p];
                w_req_size  = req_size[p*2 +: 2];
                w_req_addr  = req_addr[p*ADDR_W +: ADDR_W];
                w_req_wdata = req_wdata[p*DATA_W +: 32];
            end
        end
    end

    // Size code to byte count; code 3 behaves as a word
    always_comb begin
        case (w_req_size)
            2'd0:    w_req_n = 3'd1;
            2'd1:    w_req_n = 3'd2;
            default: w_req_n = 3'd4;
        endcase
    end

    // Read assembly: the byte addressed two edges ago is on mem_dout now
    always_comb begin
        w_rd_next = r_rdata;
        case (r_cnt)
            3'd2:    w_rd_next[7:0]   = mem_dout;
            3'd3:    w_rd_next[15:8]  = mem_dout;
            3'd4:    w_rd_next[23:16] = mem_dout;
            3'd5:    w_rd_next[31:24] = mem_dout;
            default: w_rd_next = r_rdata;
        endcase
    end

    // Write byte lane selected by the issue index
    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_wr_byte = r_wdata[7:0];
            2'd1:    w_wr_byte = r_wdata[15:8];
            2'd2:    w_wr_byte = r_wdata[23:16];
            default: w_wr_byte = r_wdata[31:24];
        endcase
    end

    // Main FSM: grant, byte-serial transfer, one-cycle response, one idle cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= PW'(NUM_PORTS - 1);
            r_wr         <= 1'b0;
            r_n          <= 3'd0;
            r_cnt        <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_mem_din    <= 8'd0;
            r_mem_a      <= '0;
            r_mem_wr     <= 1'b0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (rdy && w_gnt_found) begin
                        r_ptr   <= w_gnt_idx;
                        r_wr    <= w_req_wr;
                        r_n     <= w_req_n;
                        r_addr  <= w_req_addr;
                        r_wdata <= w_req_wdata;
                        r_rdata <= '0;
                        r_busy  <= 1'b1;
                        r_mem_a <= w_req_addr;
                        if (w_req_wr) begin
                            r_state <= S_WRITE;
                            if (w_stall_grant) begin
                                r_mem_wr <= 1'b0;
                                r_cnt    <= 3'd0;
                            end else begin
                                r_mem_din <= w_req_wdata[7:0];
                                r_mem_wr  <= 1'b1;
                                r_cnt     <= 3'd1;
                            end
                        end else begin
                            r_state  <= S_READ;
                            r_mem_wr <= 1'b0;
                            r_cnt    <= 3'd1;
                        end
                    end
                end
                S_READ: begin
                    r_rdata <= w_rd_next;
                    if (r_cnt < r_n) begin
                        r_mem_a <= r_addr + ADDR_W'(r_cnt);
                    end
                    if (r_cnt == r_n + 3'd1) begin
                        r_resp_rdata <= DATA_W'(w_rd_next);
                        r_resp_valid <= w_onehot;
                        r_state      <= S_RESP;
                    end
                    r_cnt <= r_cnt + 3'd1;
                end
                S_WRITE: begin
                    if (r_cnt == r_n) begin
                        r_mem_wr     <= 1'b0;
                        r_resp_valid <= w_onehot;
                        r_state      <= S_RESP;
                    end else if (w_stall_wr) begin
                        r_mem_wr <= 1'b0;
                    end else begin
                        r_mem_a   <= r_addr + ADDR_W'(r_cnt);
                        r_mem_din <= w_wr_byte;
                        r_mem_wr  <= 1'b1;
                        r_cnt     <= r_cnt + 3'd1;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                    r_mem_wr     <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_rr.sv
// Directed bench for mem_ctrl_rr with a 1 KiB registered-read RAM model (address bits [9:0]).
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_mem_ctrl_rr;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [1:0]  req_valid;
    logic [1:0]  req_wr;
    logic [3:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;

    logic [7:0]  ram [0:1023];
    int          checks;
    int          errors;

    mem_ctrl_rr #(
        .NUM_PORTS(2),
        .ADDR_W(32),
        .DATA_W(32),
        .IO_BASE(32'h30000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .io_buffer_full(io_buffer_full),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .req_valid(req_valid),
        .req_wr(req_wr),
        .req_size(req_size),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: write and registered read, one cycle of read latency
    always @(posedge clk) begin
        if (mem_wr === 1'b1) ram[mem_a[9:0]] <= mem_din;
        mem_dout <= ram[mem_a[9:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
        req_wr[p]             = wr;
        req_size[p*2 +: 2]    = sz;
        req_addr[p*32 +: 32]  = a;
        req_wdata[p*32 +: 32] = d;
    endtask

    task automatic test_reset;
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        tick; tick;
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got=%h exp=00", mem_din); end
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_word_read;
        set_port(0, 1'b0, 2'd2, 32'h100, 32'h0);
        req_valid = 2'b01;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_grant_busy got=%b exp=1", busy); end
        checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL wr_a0 got=%h exp=100", mem_a); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL wr_read_mem_wr got=%b exp=0", mem_wr); end
        tick;
        checks++; if (mem_a !== 32'h101) begin errors++; $display("FAIL wr_a1 got=%h exp=101", mem_a); end
        tick;
        checks++; if (mem_a !== 32'h102) begin errors++; $display("FAIL wr_a2 got=%h exp=102", mem_a); end
        tick;
        checks++; if (mem_a !== 32'h103) begin errors++; $display("FAIL wr_a3 got=%h exp=103", mem_a); end
        tick;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL wr_early_pulse got=%b exp=00", resp_valid); end
        tick;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL wr_pulse got=%b exp=01", resp_valid); end
        checks++; if (resp_rdata !== 32'h44332211) begin errors++; $display("FAIL wr_rdata got=%h exp=44332211", resp_rdata); end
        req_valid = 2'b00;
        tick;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL wr_pulse_len got=%b exp=00", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_half_write;
        set_port(1, 1'b1, 2'd1, 32'h1FF, 32'h0000BEEF);
        req_valid = 2'b10;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h1FF || mem_din !== 8'hEF) begin errors++; $display("FAIL hw_byte0 got=%b/%h/%h exp=1/1ff/ef", mem_wr, mem_a, mem_din); end
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h200 || mem_din !== 8'hBE) begin errors++; $display("FAIL hw_byte1 got=%b/%h/%h exp=1/200/be", mem_wr, mem_a, mem_din); end
        tick;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL hw_wr_drop got=%b exp=0", mem_wr); end
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL hw_pulse got=%b exp=10", resp_valid); end
        checks++; if (resp_rdata !== 32'h44332211) begin errors++; $display("FAIL hw_rdata_kept got=%h exp=44332211", resp_rdata); end
        req_valid = 2'b00;
        tick;
        checks++; if (ram[10'h1FF] !== 8'hEF || ram[10'h200] !== 8'hBE) begin errors++; $display("FAIL hw_ram got=%h/%h exp=ef/be", ram[10'h1FF], ram[10'h200]); end
        set_port(1, 1'b0, 2'd1, 32'h1FF, 32'h0);
        req_valid = 2'b10;
        tick;
        checks++; if (mem_a !== 32'h1FF) begin errors++; $display("FAIL hr_a0 got=%h exp=1ff", mem_a); end
        tick;
        checks++; if (mem_a !== 32'h200) begin errors++; $display("FAIL hr_a1 got=%h exp=200", mem_a); end
        tick;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL hr_early_pulse got=%b exp=00", resp_valid); end
        tick;
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL hr_pulse got=%b exp=10", resp_valid); end
        checks++; if (resp_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL hr_rdata got=%h exp=0000beef", resp_rdata); end
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [1:0]  exp_v;
        logic [31:0] exp_d;
        set_port(0, 1'b0, 2'd0, 32'h100, 32'h0);
        set_port(1, 1'b0, 2'd0, 32'h101, 32'h0);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_v = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (t % 2 == 0) ? 32'h11 : 32'h22;
            tick;
            checks++; if (busy !== 1'b1 || mem_a !== 32'h100 + 32'(t % 2)) begin errors++; $display("FAIL rr_grant%0d got=%b/%h exp=1/%h", t, busy, mem_a, 32'h100 + 32'(t % 2)); end
            tick;
            checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rr_early%0d got=%b exp=00", t, resp_valid); end
            tick;
            checks++; if (resp_valid !== exp_v) begin errors++; $display("FAIL rr_pulse%0d got=%b exp=%b", t, resp_valid, exp_v); end
            checks++; if (resp_rdata !== exp_d) begin errors++; $display("FAIL rr_rdata%0d got=%h exp=%h", t, resp_rdata, exp_d); end
            tick;
            checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin errors++; $display("FAIL rr_idle%0d got=%b/%b exp=0/00", t, busy, resp_valid); end
        end
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_wrap;
        set_port(0, 1'b0, 2'd2, 32'hFFFFFFFF, 32'h0);
        req_valid = 2'b01;
        tick;
        checks++; if (mem_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_a0 got=%h exp=ffffffff", mem_a); end
        tick;
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL wrap_a1 got=%h exp=0", mem_a); end
        tick;
        checks++; if (mem_a !== 32'h1) begin errors++; $display("FAIL wrap_a2 got=%h exp=1", mem_a); end
        tick;
        checks++; if (mem_a !== 32'h2) begin errors++; $display("FAIL wrap_a3 got=%h exp=2", mem_a); end
        tick; tick;
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL wrap_pulse got=%b exp=01", resp_valid); end
        checks++; if (resp_rdata !== 32'hD4C3B2A1) begin errors++; $display("FAIL wrap_rdata got=%h exp=d4c3b2a1", resp_rdata); end
        req_valid = 2'b00;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy got=%b exp=0", busy); end
    endtask

    task automatic test_size3;
        set_port(0, 1'b0, 2'd3, 32'h100, 32'h0);
        req_valid = 2'b01;
        tick; tick; tick; tick; tick;
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL sz3_early got=%b exp=00", resp_valid); end
        tick;
        checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h44332211) begin errors++; $display("FAIL sz3_pulse got=%b/%h exp=01/44332211", resp_valid, resp_rdata); end
        req_valid = 2'b00;
        tick;
    endtask

    task automatic test_rdy;
        rdy = 1'b0;
        set_port(0, 1'b0, 2'd0, 32'h102, 32'h0);
        req_valid = 2'b01;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdy_hold0 got=%b exp=0", busy); end
        tick;
        checks++; if (busy !== 1'b0 || mem_a !== 32'h103) begin errors++; $display("FAIL rdy_hold1 got=%b/%h exp=0/103", busy, mem_a); end
        rdy = 1'b1;
        tick;
        checks++; if (busy !== 1'b1 || mem_a !== 32'h102) begin errors++; $display("FAIL rdy_grant got=%b/%h exp=1/102", busy, mem_a); end
        rdy = 1'b0;
        tick; tick;
        checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'h33) begin errors++; $display("FAIL rdy_mid got=%b/%h exp=01/33", resp_valid, resp_rdata); end
        req_valid = 2'b00;
        rdy = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid;
        set_port(1, 1'b1, 2'd2, 32'h40, 32'hCAFEF00D);
        req_valid = 2'b10;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h40 || mem_din !== 8'h0D) begin errors++; $display("FAIL rm_byte0 got=%b/%h/%h exp=1/40/0d", mem_wr, mem_a, mem_din); end
        tick;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h42 || mem_din !== 8'hFE) begin errors++; $display("FAIL rm_byte2 got=%b/%h/%h exp=1/42/fe", mem_wr, mem_a, mem_din); end
        rst = 1'b0;
        tick;
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rm_mem_wr got=%b exp=0", mem_wr); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rm_resp got=%b exp=00", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
        rst = 1'b1;
        req_valid = 2'b00;
        tick;
        checks++; if (resp_valid !== 2'b00 || ram[10'h43] !== 8'h00) begin errors++; $display("FAIL rm_aborted got=%b/%h exp=00/00", resp_valid, ram[10'h43]); end
        set_port(0, 1'b0, 2'd0, 32'h41, 32'h0);
        req_valid = 2'b01;
        tick;
        checks++; if (busy !== 1'b1 || mem_a !== 32'h41) begin errors++; $display("FAIL rm_regrant got=%b/%h exp=1/41", busy, mem_a); end
        tick; tick;
        checks++; if (resp_valid !== 2'b01 || resp_rdata !== 32'hF0) begin errors++; $display("FAIL rm_read got=%b/%h exp=01/f0", resp_valid, resp_rdata); end
        req_valid = 2'b00;
        tick;
    endtask

`ifdef IO_BUFFER_FULL_STALL_EN
    task automatic test_io_stall;
        set_port(0, 1'b1, 2'd0, 32'h30000, 32'h41);
        io_buffer_full = 1'b1;
        req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++; if (mem_wr !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL io_stall%0d got=%b/%b exp=0/1", c, mem_wr, busy); end
        end
        io_buffer_full = 1'b0;
        tick;
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_din !== 8'h41) begin errors++; $display("FAIL io_write got=%b/%h/%h exp=1/30000/41", mem_wr, mem_a, mem_din); end
        tick;
        checks++; if (mem_wr !== 1'b0 || resp_valid !== 2'b01) begin errors++; $display("FAIL io_done got=%b/%b exp=0/01", mem_wr, resp_valid); end
        req_valid = 2'b00;
        tick;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h3FF] = 8'hA1; ram[10'h000] = 8'hB2; ram[10'h001] = 8'hC3; ram[10'h002] = 8'hD4;
        test_reset;
        test_word_read;
        test_half_write;
        test_back_to_back;
        test_wrap;
        test_size3;
        test_rdy;
        test_reset_mid;
`ifdef IO_BUFFER_FULL_STALL_EN
        test_io_stall;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
